tag_lookup_pipe: RTL and testbench

Two-stage pipelined tag-lookup and way-select stage for the L2 cache model; successor to the combinational hit/line output logic. Takes one set's worth of tags, valid bits and line data per request, compares all ways against the address tag, encodes the winning way, selects the line, and returns a registered response through a valid/ready handshake with full backpressure. Adds multi-hit detection, request-ID passthrough and optional hit/miss statistics.

---
 rtl/tag_lookup_pipe.sv | 187 ++++++++++++++++++
 tb/tb_tag_lookup_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tag_lookup_pipe
// Two-stage tag compare / way select with valid-ready backpressure.
// Optional macro LOOKUP_STATS_EN adds saturating hit/miss counters.
// Revision: 1.0
// ============================================================================
module tag_lookup_pipe #(
  parameter int TAG_BITS   = 12,
  parameter int LINE_SIZE  = 512,
  parameter int WAYS       = 8,
  parameter int ID_BITS    = 4,
  parameter int COUNT_BITS = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic [TAG_BITS-1:0]         reqTag,
  input  logic [WAYS-1:0]             reqWayValid,
  input  logic [TAG_BITS*WAYS-1:0]    reqCacheTag,
  input  logic [LINE_SIZE*WAYS-1:0]   reqCacheData,
  input  logic [ID_BITS-1:0]          reqId,
  output logic                        rspValid,
  input  logic                        rspReady,
  output logic                        rspHit,
  output logic [$clog2(WAYS)-1:0]     rspWay,
  output logic [LINE_SIZE-1:0]        rspLine,
  output logic                        rspMultiHit,
`ifdef LOOKUP_STATS_EN
  output logic [COUNT_BITS-1:0]       hitCount,
  output logic [COUNT_BITS-1:0]       missCount,
  input  logic                        clearStats,
`endif
  output logic [ID_BITS-1:0]          rspId
);

  localparam int WAY_W = $clog2(WAYS);

  logic [WAYS-1:0]           match;
  logic                      accept, s1_advance, s2_advance;

  logic                      s1_valid_q, s1_valid_d;
  logic [WAYS-1:0]           s1_match_q, s1_match_d;
  logic [LINE_SIZE*WAYS-1:0] s1_data_q, s1_data_d;
  logic [ID_BITS-1:0]        s1_id_q, s1_id_d;

  logic [WAYS-1:0]           first_hot;
  logic [WAY_W-1:0]          sel_way;
  logic [LINE_SIZE-1:0]      sel_line;

  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_hit_q, s2_hit_d;
  logic [WAY_W-1:0]          s2_way_q, s2_way_d;
  logic [LINE_SIZE-1:0]      s2_line_q, s2_line_d;
  logic                      s2_multi_q, s2_multi_d;
  logic [ID_BITS-1:0]        s2_id_q, s2_id_d;

  generate
    for (genvar i = 0; i < WAYS; i++) begin : g_match
      assign match[i] = reqWayValid[i] && (reqCacheTag[i*TAG_BITS +: TAG_BITS] == reqTag);
    end
  endgenerate

  assign s2_advance = !s2_valid_q || rspReady;
  assign s1_advance = s1_valid_q && s2_advance;
  assign reqReady   = !s1_valid_q || s2_advance;
  assign accept     = reqValid && reqReady;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_match_d = s1_match_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_match_d = match;
      s1_data_d  = reqCacheData;
      s1_id_d    = reqId;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Isolate the lowest set match bit; a miss leaves way and line at zero.
  assign first_hot = s1_match_q & (~s1_match_q + WAYS'(1));

  always_comb begin
    sel_way  = '0;
    sel_line = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (first_hot[i]) begin
        sel_way  = WAY_W'(i);
        sel_line = s1_data_q[i*LINE_SIZE +: LINE_SIZE];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_hit_d   = s2_hit_q;
    s2_way_d   = s2_way_q;
    s2_line_d  = s2_line_q;
    s2_multi_d = s2_multi_q;
    s2_id_d    = s2_id_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_hit_d   = |s1_match_q;
      s2_way_d   = sel_way;
      s2_line_d  = sel_line;
      s2_multi_d = |(s1_match_q & (s1_match_q - WAYS'(1)));
      s2_id_d    = s1_id_q;
    end else if (s2_advance) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_way_q   <= '0;
      s2_line_q  <= '0;
      s2_multi_q <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_match_q <= s1_match_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_hit_q   <= s2_hit_d;
      s2_way_q   <= s2_way_d;
      s2_line_q  <= s2_line_d;
      s2_multi_q <= s2_multi_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign rspValid    = s2_valid_q;
  assign rspHit      = s2_hit_q;
  assign rspWay      = s2_way_q;
  assign rspLine     = s2_line_q;
  assign rspMultiHit = s2_multi_q;
  assign rspId       = s2_id_q;

`ifdef LOOKUP_STATS_EN
  logic [COUNT_BITS-1:0] hit_count_q, hit_count_d;
  logic [COUNT_BITS-1:0] miss_count_q, miss_count_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (clearStats) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (s2_valid_q && rspReady) begin
      if (s2_hit_q) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + COUNT_BITS'(1);
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + COUNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hitCount  = hit_count_q;
  assign missCount = miss_count_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_lookup_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_tag_lookup_pipe
// Directed stimulus for tag_lookup_pipe checked against an in-order
// reference queue; stats checks are compiled when LOOKUP_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module tb_tag_lookup_pipe;

  localparam int TAGB = 12;
  localparam int LINE = 512;
  localparam int WAYS = 8;
  localparam int IDB  = 4;
  localparam int CNTB = 3;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 reqValid = 1'b0;
  logic                 reqReady;
  logic [TAGB-1:0]      reqTag = '0;
  logic [WAYS-1:0]      reqWayValid = '0;
  logic [TAGB*WAYS-1:0] reqCacheTag = '0;
  logic [LINE*WAYS-1:0] reqCacheData = '0;
  logic [IDB-1:0]       reqId = '0;
  logic                 rspValid;
  logic                 rspReady = 1'b1;
  logic                 rspHit;
  logic [2:0]           rspWay;
  logic [LINE-1:0]      rspLine;
  logic                 rspMultiHit;
  logic [IDB-1:0]       rspId;
`ifdef LOOKUP_STATS_EN
  logic [CNTB-1:0]      hitCount, missCount;
  logic                 clearStats = 1'b0;
  int                   hc = 0, mc = 0;
`endif

  int tests = 0, fails = 0;
  int cyc = 0, acc_seen = 0, rsp_seen = 0;

  tag_lookup_pipe #(.TAG_BITS(TAGB), .LINE_SIZE(LINE), .WAYS(WAYS), .ID_BITS(IDB), .COUNT_BITS(CNTB)) dut (
    .clock(clock), .reset_n(reset_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqTag(reqTag),
    .reqWayValid(reqWayValid), .reqCacheTag(reqCacheTag), .reqCacheData(reqCacheData),
    .reqId(reqId), .rspValid(rspValid), .rspReady(rspReady), .rspHit(rspHit),
    .rspWay(rspWay), .rspLine(rspLine), .rspMultiHit(rspMultiHit),
`ifdef LOOKUP_STATS_EN
    .hitCount(hitCount), .missCount(missCount), .clearStats(clearStats),
`endif
    .rspId(rspId)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            hit;
    logic [2:0]      way;
    logic [LINE-1:0] line;
    logic            multi;
    logic [IDB-1:0]  id;
    int              cyc;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [LINE-1:0] line_of(input int s);
    logic [LINE-1:0] l;
    for (int k = 0; k < LINE/32; k++)
      l[k*32 +: 32] = (32'(s + 1) * 32'h9E3779B9) ^ (32'(k) * 32'h01000193 + 32'd7);
    return l;
  endfunction

  // Reference: scan every way, keep the lowest-indexed valid tag match.
  function automatic exp_t model(input logic [TAGB-1:0] tag, input logic [WAYS-1:0] wv,
                                 input logic [TAGB*WAYS-1:0] ct, input logic [LINE*WAYS-1:0] d,
                                 input logic [IDB-1:0] id, input int c);
    exp_t e;
    int n = 0;
    e.hit = 1'b0; e.way = '0; e.line = '0; e.multi = 1'b0; e.id = id; e.cyc = c;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (wv[i] && ct[i*TAGB +: TAGB] == tag) begin
        n++;
        e.hit = 1'b1; e.way = 3'(i); e.line = d[i*LINE +: LINE];
      end
    end
    e.multi = (n >= 2);
    return e;
  endfunction

  // Compare process: outputs sampled on the falling edge, handshakes
  // judged for the following rising edge.
  logic            hold = 1'b0;
  logic            p_hit, p_multi;
  logic [2:0]      p_way;
  logic [LINE-1:0] p_line;
  logic [IDB-1:0]  p_id;

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_rspValid", rspValid, 0);
      expq.delete();
      hold = 1'b0;
`ifdef LOOKUP_STATS_EN
      hc = 0; mc = 0;
`endif
    end else begin
      logic exp_v;
      logic hs;
      cyc++;
      exp_v = (expq.size() > 0) && (expq[0].cyc + 2 <= cyc);
      chk("rspValid", rspValid, exp_v);
      if (hold) begin
        chk("hold_hit", rspHit, p_hit);
        chk("hold_way", rspWay, p_way);
        chk("hold_line", rspLine, p_line);
        chk("hold_multi", rspMultiHit, p_multi);
        chk("hold_id", rspId, p_id);
      end
`ifdef LOOKUP_STATS_EN
      chk("hitCount", hitCount, CNTB'(hc));
      chk("missCount", missCount, CNTB'(mc));
`endif
      hs = exp_v && rspReady;
      if (hs) begin
        chk("rsp_hit", rspHit, expq[0].hit);
        chk("rsp_way", rspWay, expq[0].way);
        chk("rsp_line", rspLine, expq[0].line);
        chk("rsp_multi", rspMultiHit, expq[0].multi);
        chk("rsp_id", rspId, expq[0].id);
        rsp_seen++;
      end
`ifdef LOOKUP_STATS_EN
      if (clearStats) begin
        hc = 0; mc = 0;
      end else if (hs) begin
        if (expq[0].hit) hc = (hc < (1 << CNTB) - 1) ? hc + 1 : hc;
        else             mc = (mc < (1 << CNTB) - 1) ? mc + 1 : mc;
      end
`endif
      if (hs) void'(expq.pop_front());
      chk("inflight_le2", expq.size() <= 2, 1);
      if (reqValid && reqReady) begin
        expq.push_back(model(reqTag, reqWayValid, reqCacheTag, reqCacheData, reqId, cyc));
        acc_seen++;
      end
      hold = rspValid && !rspReady;
      p_hit = rspHit; p_way = rspWay; p_line = rspLine; p_multi = rspMultiHit; p_id = rspId;
    end
  end

  task automatic build(input logic [TAGB-1:0] tag, input logic [WAYS-1:0] wv,
                       input logic [WAYS-1:0] hm, input int seed, input logic [IDB-1:0] id);
    reqTag = tag; reqWayValid = wv; reqId = id;
    for (int i = 0; i < WAYS; i++) begin
      reqCacheTag[i*TAGB +: TAGB]  = hm[i] ? tag : (tag ^ TAGB'(i + 1));
      reqCacheData[i*LINE +: LINE] = line_of(seed*8 + i);
    end
  endtask

  task automatic send(input logic [TAGB-1:0] tag, input logic [WAYS-1:0] wv,
                      input logic [WAYS-1:0] hm, input int seed, input logic [IDB-1:0] id);
    int n = 0;
    build(tag, wv, hm, seed, id);
    reqValid = 1'b1;
    @(negedge clock);
    while (!reqReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: got reqReady=0 for %0d cycles expected accept", n);
    end
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin
    int a0, r0;
    time t0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rspValid", rspValid, 0);
    chk("reset_rspHit", rspHit, 0);
    chk("reset_rspWay", rspWay, 0);
    chk("reset_rspLine", rspLine, 0);
    chk("reset_rspMulti", rspMultiHit, 0);
    chk("reset_rspId", rspId, 0);
    #2 reset_n = 1'b1;
    #1 chk("reset_reqReady", reqReady, 1);

    // Single hit in way 3
    @(posedge clock); #1;
    send(12'h0A5, 8'hFF, 8'h08, 1, 4'd7);
    @(posedge clock);
    @(negedge clock);
    chk("t1_valid", rspValid, 1);
    chk("t1_hit", rspHit, 1);
    chk("t1_way", rspWay, 3);
    chk("t1_line", rspLine, line_of(1*8 + 3));
    chk("t1_multi", rspMultiHit, 0);
    chk("t1_id", rspId, 7);
    drain();

    // Way 5 tag matches but is invalid
    send(12'h3C1, 8'hDF, 8'h20, 2, 4'd2);
    @(posedge clock);
    @(negedge clock);
    chk("t2_valid", rspValid, 1);
    chk("t2_hit", rspHit, 0);
    chk("t2_way", rspWay, 0);
    chk("t2_line", rspLine, 0);
    drain();

    // Ways 2 and 6 both hit: lowest wins
    send(12'h777, 8'hFF, 8'h44, 3, 4'd9);
    @(posedge clock);
    @(negedge clock);
    chk("t3_hit", rspHit, 1);
    chk("t3_way", rspWay, 2);
    chk("t3_multi", rspMultiHit, 1);
    chk("t3_line", rspLine, line_of(3*8 + 2));
    drain();

    // Ten back-to-back requests, one per cycle
    r0 = rsp_seen;
    t0 = $time;
    for (int k = 0; k < 10; k++)
      send(TAGB'(12'h100 + k), 8'hFF ^ 8'(k*5), 8'(k*37), 10 + k, IDB'(k));
    chk("b2b_cycles", 32'($time - t0), 32'd100);
    drain();
    chk("b2b_responses", rsp_seen - r0, 10);

    // Backpressure: two accepts then reqReady held low
    a0 = acc_seen;
    rspReady = 1'b0;
    fork
      begin
        send(12'h011, 8'hFF, 8'h01, 30, 4'd10);
        send(12'h022, 8'h0F, 8'hF0, 31, 4'd11);
        send(12'h033, 8'hFF, 8'h81, 32, 4'd12);
      end
      begin
        repeat (5) @(posedge clock);
        #2;
        chk("bp_accepts", acc_seen - a0, 2);
        chk("bp_reqReady", reqReady, 0);
        rspReady = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", acc_seen - a0, 3);

    // Reset with two requests in flight
    rspReady = 1'b0;
    send(12'h0AA, 8'hFF, 8'h10, 40, 4'd1);
    send(12'h0BB, 8'hFF, 8'h02, 41, 4'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rspValid", rspValid, 0);
    chk("midrst_rspHit", rspHit, 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    rspReady = 1'b1;
    r0 = rsp_seen;
    repeat (6) @(posedge clock);
    #1;
    chk("midrst_no_stale", rsp_seen - r0, 0);
    chk("midrst_valid_low", rspValid, 0);

`ifdef LOOKUP_STATS_EN
    for (int k = 0; k < 5; k++)
      send(12'h050, 8'hFF, (k % 2 == 0) ? 8'h04 : 8'h00, 50 + k, IDB'(k));
    drain();
    chk("stats_hit3", hitCount, 3);
    chk("stats_miss2", missCount, 2);
    send(12'h060, 8'hFF, 8'h01, 60, 4'd3);
    @(posedge clock); #1;
    clearStats = 1'b1;
    @(posedge clock); #1;
    clearStats = 1'b0;
    chk("stats_clr_hit", hitCount, 0);
    chk("stats_clr_miss", missCount, 0);
    for (int k = 0; k < 18; k++)
      send(12'h070, 8'hFF, (k < 9) ? 8'h80 : 8'h00, 70 + k, IDB'(k));
    drain();
    chk("stats_sat_hit", hitCount, 3'h7);
    chk("stats_sat_miss", missCount, 3'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
